gray_codec_pipe: RTL

//  Parametrised, pipelined binary<->Gray code converter with a valid/ready stream interface.

---
 rtl/gray_codec_pipe_if.sv | 27 ++
 rtl/gray_codec_pipe.sv | 117 +++++++++++
 2 files changed

// File: rtl/gray_codec_pipe_if.sv
// Stream bundle for gray_codec_pipe: input side (producer -> codec) and
// output side (codec -> consumer), both valid/ready.
interface gray_codec_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_mode;
    logic             out_err;

    // Environment side: offers input items and accepts output items.
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_err
    );

    // Codec side.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_err
    );
endinterface

// File: rtl/gray_codec_pipe.sv
// Two-stage pipelined binary<->Gray converter with valid/ready handshake.
// S1 holds the item as plain binary (or the raw word for reserved mode);
// S2 is the output register. in_ready is combinational from out_ready.
module gray_codec_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    gray_codec_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_B2G  = 2'b00,
        MODE_G2B  = 2'b01,
        MODE_GINC = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Each binary bit is the XOR of the Gray bits at and above its position.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic             s1_v;
    mode_e            s1_mode;
    logic [WIDTH-1:0] s1_word;

    logic             s2_v;
    mode_e            s2_mode;
    logic [WIDTH-1:0] s2_data;
    logic             s2_err;

    logic             in_xfer;
    logic             s2_adv;
    mode_e            in_mode_e;
    logic [WIDTH-1:0] s1_next_word;
    logic [WIDTH-1:0] s2_next_data;
    logic             s2_next_err;

    assign s2_adv       = s1_v & (~s2_v | bus.out_ready);
    assign bus.in_ready = rst_n & (~s1_v | s2_adv);
    assign in_xfer      = bus.in_valid & bus.in_ready;

    // S1 input decode: Gray inputs are normalised to binary, binary and
    // reserved-mode words are kept as received.
    always_comb begin
        in_mode_e    = mode_e'(bus.in_mode);
        s1_next_word = bus.in_data;
        if (in_mode_e == MODE_G2B || in_mode_e == MODE_GINC) begin
            s1_next_word = g2b(bus.in_data);
        end
    end

    // S2 output computation from the binary value held in S1.
    always_comb begin
        s2_next_data = s1_word;
        s2_next_err  = 1'b0;
        case (s1_mode)
            MODE_B2G:  s2_next_data = b2g(s1_word);
            MODE_G2B:  s2_next_data = s1_word;
            MODE_GINC: s2_next_data = b2g(s1_word + WIDTH'(1));
            MODE_RSVD: begin
                s2_next_data = s1_word;
                s2_next_err  = 1'b1;
            end
            default:   s2_next_data = s1_word;
        endcase
    end

    // S1 register: load on input transfer, empty when its item moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_mode <= MODE_B2G;
            s1_word <= '0;
        end else if (in_xfer) begin
            s1_v    <= 1'b1;
            s1_mode <= in_mode_e;
            s1_word <= s1_next_word;
        end else if (s2_adv) begin
            s1_v    <= 1'b0;
        end
    end

    // S2 output register: reload from S1 when possible, otherwise drain on
    // consumer accept; contents hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_mode <= MODE_B2G;
            s2_data <= '0;
            s2_err  <= 1'b0;
        end else if (s2_adv) begin
            s2_v    <= 1'b1;
            s2_mode <= s1_mode;
            s2_data <= s2_next_data;
            s2_err  <= s2_next_err;
        end else if (bus.out_ready) begin
            s2_v    <= 1'b0;
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.out_data  = s2_data;
    assign bus.out_mode  = s2_mode;
    assign bus.out_err   = s2_err;

endmodule
